data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for CPU load/store traffic. Accepts one word-addressed read/write
//  request over a valid/ready handshake, inserts programmable wait states, then returns data
//  or an error over a second valid/ready handshake. Sits between the CPU's data-access
//  initiator and the data RAM, replacing the zero-latency DataMem path.
// PARAMETERS
//  DEPTH        256  number of 32-bit words; byte address range 0 .. 4*DEPTH-1
//  WAIT_CYCLES  2    extra wait states between request accept and response (0..15)
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request (high only in IDLE)
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   32  byte address; word index = req_addr[31:2]
//  req_wdata   in   32  store data
//  req_be      in   4   byte enables for store; be[i] writes wdata[8i+7:8i]
//  resp_valid  out  1   response present
//  resp_ready  in   1   initiator accepts response
//  resp_rdata  out  32  load data (0 for stores and errors)
//  resp_err    out  1   1 = misaligned or out-of-range access
// BEHAVIOUR
//  - Reset: state IDLE, wait counter 0, req_ready=1 after reset edge, resp_valid=0,
//    resp_rdata=0, resp_err=0. RAM contents are NOT cleared by rst.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: req_ready=1. At edge with req_valid&req_ready: latch write/addr/wdata/be,
//      load counter=WAIT_CYCLES, go WAIT.
//    WAIT: req_ready=0. If counter==0 go RESP at next edge (performing access on that edge),
//      else decrement.
//    RESP: resp_valid=1; resp_rdata/resp_err held stable until edge with resp_ready=1,
//      then go IDLE and drop resp_valid.
//  - Latency: request accepted at edge k -> resp_valid high after edge k+1+WAIT_CYCLES.
//    Minimum request-to-request period WAIT_CYCLES+3 cycles (resp_ready held high).
//  - Error: req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH. No RAM write; resp_rdata=0, resp_err=1.
//  - Load: resp_rdata = RAM[word index] sampled on WAIT->RESP edge.
//  - Store: bytes with be set written on WAIT->RESP edge; resp_rdata=0, resp_err=0.
//    req_be=0 store: no RAM change, completes normally.
//  - Request inputs ignored outside IDLE; only latched copies used after accept.
//  - Response backpressure: resp_ready low keeps RESP indefinitely, outputs unchanged.
//  - rst mid-operation (WAIT or RESP): pending request dropped, no RAM write if reset edge
//    coincides with WAIT->RESP edge; return to IDLE, outputs to reset values.
//  - rst asserted with req_valid=1: request not accepted.
// TESTING
//  1 Reset: rst high 2 cycles -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
//  2 WAIT_CYCLES=2: store addr 0x10 data 0xDEADBEEF be=1111, then load 0x10 -> resp_valid
//    3 cycles after each accept edge; load returns 0xDEADBEEF, resp_err=0.
//  3 Partial store: word 0x20=0x11223344, store 0xAABBCCDD be=0101 -> load 0x20 = 0x11BB33DD.
//  4 Errors: load 0x22 (misaligned) and store to 4*DEPTH -> resp_err=1, rdata=0; reload
//    neighbouring words shows no change.
//  5 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata, err stable,
//    req_ready=0; release -> IDLE next cycle, req_ready=1.
//  6 Reset mid-WAIT on a store to 0x30 (old 0x0) -> IDLE, no response; load 0x30 returns 0x0.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Word-addressed data RAM behind a request/response handshake
//               pair, with a programmable number of wait states per access.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic             w_accept;
    logic             w_access;
    logic             w_err;
    logic [IDX_W-1:0] w_word_idx;

    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_access   = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_word_idx = r_addr[IDX_W+1:2];
    // Range check uses the full word index so high address bits cannot alias.
    assign w_err      = (r_addr[1:0] != 2'b00) ||
                        ({2'b00, r_addr[31:2]} >= 32'(DEPTH));

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_valid)      w_state_nxt = ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd0)  w_state_nxt = ST_RESP;
            ST_RESP: if (resp_ready)     w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_cnt   <= C_WAIT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (!r_write && !w_err) ? r_mem[w_word_idx] : 32'd0;
            end else if ((r_state == ST_RESP) && resp_ready) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && w_access && r_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_word_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Scoreboard bench for data_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int DEPTH       = 256;
    localparam int WAIT_CYCLES = 2;
    localparam int TIMEOUT     = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          vectors = 0;
    int          miscompares = 0;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, push its expected response, then check latency and data.
    task automatic transact(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input int hold_cycles);
        exp_t        e;
        int          lat;
        logic [31:0] held_rdata;
        logic        held_err;
        logic [31:0] idx;
        idx = addr >> 2;
        e.err   = (addr[1:0] != 2'b00) || (idx >= DEPTH);
        e.rdata = 32'd0;
        if (!e.err && !wr) e.rdata = model[idx];
        if (!e.err && wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        sb.push_back(e);

        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ready addr=%h got=%b want=1", addr, req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        tick();
        // Scramble request inputs: only the latched copy may be used.
        req_valid = 1'b0; req_write = ~wr; req_addr = addr ^ 32'h0000_0044;
        req_wdata = ~wdata; req_be = ~be;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < TIMEOUT) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat != WAIT_CYCLES + 1) begin
            miscompares++;
            $display("FAIL latency addr=%h got=%0d want=%0d", addr, lat, WAIT_CYCLES + 1);
        end
        if (resp_valid !== 1'b1) begin
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
            miscompares++;
            $display("FAIL resp addr=%h got=%h/%b want=%h/%b", addr, resp_rdata, resp_err,
                     e.rdata, e.err);
        end
        held_rdata = resp_rdata;
        held_err   = resp_err;
        for (int c = 0; c < hold_cycles; c++) begin
            tick();
            vectors++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 ||
                resp_rdata !== held_rdata || resp_err !== held_err) begin
                miscompares++;
                $display("FAIL backpressure cyc=%0d got v=%b r=%b d=%h e=%b want v=1 r=0 d=%h e=%b",
                         c, resp_valid, req_ready, resp_rdata, resp_err, held_rdata, held_err);
            end
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release got v=%b r=%b want v=0 r=1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_addr = 32'h10;
        tick();
        tick();
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset got r=%b v=%b d=%h e=%b want 1 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        req_valid = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_no_accept got v=%b r=%b want v=0 r=1", resp_valid, req_ready);
        end
    endtask

    task automatic test_store_load();
        transact(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0);
        transact(1'b0, 32'h10, 32'h0, 4'b0000, 0);
    endtask

    task automatic test_partial_store();
        transact(1'b1, 32'h20, 32'h11223344, 4'b1111, 0);
        transact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
        transact(1'b0, 32'h20, 32'h0, 4'b0000, 0);
        vectors++;
        if (model[8] !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL partial_model got=%h want=11bb33dd", model[8]);
        end
        transact(1'b1, 32'h20, 32'h55555555, 4'b0000, 0);
        transact(1'b0, 32'h20, 32'h0, 4'b0000, 0);
    endtask

    task automatic test_errors();
        transact(1'b1, 32'h3FC, 32'hCAFEF00D, 4'b1111, 0);
        transact(1'b1, 32'h24, 32'h01020304, 4'b1111, 0);
        transact(1'b0, 32'h22, 32'h0, 4'b0000, 0);
        transact(1'b1, 32'h23, 32'hFFFFFFFF, 4'b1111, 0);
        transact(1'b1, 32'(4*DEPTH), 32'h12345678, 4'b1111, 0);
        transact(1'b1, 32'h8000_0000, 32'h12345678, 4'b1111, 0);
        transact(1'b0, 32'(4*DEPTH), 32'h0, 4'b0000, 0);
        transact(1'b0, 32'h3FC, 32'h0, 4'b0000, 0);
        transact(1'b0, 32'h20, 32'h0, 4'b0000, 0);
        transact(1'b0, 32'h24, 32'h0, 4'b0000, 0);
        transact(1'b0, 32'h0, 32'h0, 4'b0000, 0);
    endtask

    task automatic test_backpressure();
        transact(1'b0, 32'h10, 32'h0, 4'b0000, 5);
        transact(1'b1, 32'h40, 32'h0BADF00D, 4'b1111, 5);
        transact(1'b0, 32'h40, 32'h0, 4'b0000, 3);
    endtask

    // kill_edges = edges after accept before the reset edge; WAIT_CYCLES hits the access edge.
    task automatic reset_during_store(input logic [31:0] addr, input int kill_edges);
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = 32'hFFFFFFFF; req_be = 4'b1111;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < kill_edges; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid kill=%0d got r=%b v=%b d=%h e=%b want 1 0 0 0",
                     kill_edges, req_ready, resp_valid, resp_rdata, resp_err);
        end
        for (int c = 0; c < WAIT_CYCLES + 3; c++) begin
            tick();
            vectors++;
            if (resp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_no_resp kill=%0d cyc=%0d got v=%b want v=0", kill_edges, c, resp_valid);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        transact(1'b1, 32'h30, 32'h00000000, 4'b1111, 0);
        reset_during_store(32'h30, 0);
        transact(1'b0, 32'h30, 32'h0, 4'b0000, 0);
        reset_during_store(32'h30, WAIT_CYCLES);
        transact(1'b0, 32'h30, 32'h0, 4'b0000, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            transact(1'b1, 32'(32'h100 + 4*i), $urandom, 4'($urandom_range(0, 15)), 0);
        end
        for (int i = 0; i < 6; i++) begin
            transact(1'b0, 32'(32'h100 + 4*i), 32'h0, 4'b0000, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        test_reset();
        // RAM is uninitialised; give every word the model assumes a known value.
        for (int i = 0; i < 16; i++) transact(1'b1, 32'(4*i), 32'd0, 4'b1111, 0);
        for (int i = 0; i < 8; i++) transact(1'b1, 32'(32'h100 + 4*i), 32'd0, 4'b1111, 0);
        test_store_load();
        test_partial_store();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
